// File: rtl/present_decrypt_if.sv
// Start/done handshake bundle for the PRESENT-80 decryption core.
// The master drives the request and operands; the slave (the core) returns
// the plaintext and status.
interface present_decrypt_if;
  logic        start;
  logic [79:0] key;
  logic [63:0] ciphertext;
  logic [63:0] plaintext;
  logic        busy;
  logic        done;

  modport master (output start, key, ciphertext, input plaintext, busy, done);
  modport slave  (input start, key, ciphertext, output plaintext, busy, done);
endinterface

// File: rtl/present_decrypt_core.sv
// Iterative PRESENT-80 decryption core.
// A run first replays the forward key schedule to reach K32 (EXPAND) and
// applies the final whitening key. It then walks the schedule backwards one
// round per clock (DECRYPT), undoing P-layer and S-box layer and adding K_rc.
// When a run ends, kreg has unwound back to the user key.
module present_decrypt_core #(
  parameter int size     = 64,
  parameter int key_bits = 80,
  parameter int rounds   = 31
) (
  input  logic             clk,
  input  logic             reset,
  present_decrypt_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DECRYPT
  } fsm_t;

  localparam logic [4:0] last_rc = 5'(rounds);

  fsm_t                fsm;
  fsm_t                fsm_next;
  logic [size-1:0]     state;
  logic [key_bits-1:0] kreg;
  logic [4:0]          rc;

  logic [key_bits-1:0] kf;
  logic [key_bits-1:0] kn;
  logic [size-1:0]     round_out;

  // Forward PRESENT S-box.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Inverse PRESENT S-box.
  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Forward key-register update: rotate left 61, S-box top nibble, add counter.
  function automatic logic [key_bits-1:0] key_fwd(input logic [key_bits-1:0] k,
                                                  input logic [4:0] i);
    logic [key_bits-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ i;
    return r;
  endfunction

  // Exact inverse of key_fwd for the same counter value.
  function automatic logic [key_bits-1:0] key_inv(input logic [key_bits-1:0] k,
                                                  input logic [4:0] i);
    logic [key_bits-1:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ i;
    r[79:76]   = inv_sbox(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  // Bit j of the result is the bit the forward P-layer placed at P(j).
  function automatic logic [size-1:0] inv_player(input logic [size-1:0] x);
    logic [size-1:0] y;
    for (int j = 0; j < 64; j++) begin
      y[j] = x[(j == 63) ? 63 : (16 * j) % 63];
    end
    return y;
  endfunction

  function automatic logic [size-1:0] inv_sbox_layer(input logic [size-1:0] x);
    logic [size-1:0] y;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
    end
    return y;
  endfunction

  assign kf        = key_fwd(kreg, rc);
  assign kn        = key_inv(kreg, rc);
  assign round_out = inv_sbox_layer(inv_player(state)) ^ kn[key_bits-1:key_bits-size];

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_next;
  end

  // Next-state logic: accept in IDLE, 31 expand steps, 31 inverse rounds.
  always_comb begin
    // NOTE: default assigned before the case so no path leaves fsm_next unassigned (no latch).
    fsm_next = fsm;
    unique case (fsm)
      IDLE:    if (bus.start)       fsm_next = EXPAND;
      EXPAND:  if (rc == last_rc)   fsm_next = DECRYPT;
      DECRYPT: if (rc == 5'd1)      fsm_next = IDLE;
      default:                      fsm_next = IDLE;
    endcase
  end

  // Datapath, key register, round counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= '0;
      kreg          <= '0;
      rc            <= '0;
      bus.plaintext <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      bus.done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.start) begin
            state    <= bus.ciphertext;
            kreg     <= bus.key;
            rc       <= 5'd1;
            bus.busy <= 1'b1;
          end
        end
        EXPAND: begin
          kreg <= kf;
          if (rc == last_rc) begin
            // K32 whitening; rc stays at 31 to start the backward walk.
            state <= state ^ kf[key_bits-1:key_bits-size];
          end else begin
            rc <= rc + 5'd1;
          end
        end
        DECRYPT: begin
          kreg  <= kn;
          state <= round_out;
          if (rc == 5'd1) begin
            bus.plaintext <= round_out;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            rc <= rc - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
